// File: rtl/serial_pattern_generator.sv
// Serializes a latched PAT_W-bit pattern MSB first onto d_out/valid_out,
// repeating it a programmed number of times with an idle gap between repetitions.
module serial_pattern_generator #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [CNT_W-1:0] repeat_in,
  input  logic [GAP_W-1:0] gap_in,
  input  logic             ready_in,
  output logic             d_out,
  output logic             valid_out,
  output logic             busy,
  output logic             pattern_sent,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           state, state_n;
  logic [PAT_W-1:0] pat, pat_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [GAP_W-1:0] gap_len, gap_len_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             d_n, valid_n, busy_n, sent_n, done_n;
  logic             xfer;

  // Handshake: a bit moves when valid_out && ready_in in the same cycle; while
  // ready_in is low, d_out/valid_out and the bit index hold unchanged.
  assign xfer = valid_out && ready_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pat          <= '0;
      idx          <= '0;
      rem          <= '0;
      gap_len      <= '0;
      gap_cnt      <= '0;
      d_out        <= 1'b0;
      valid_out    <= 1'b0;
      busy         <= 1'b0;
      pattern_sent <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      pat          <= pat_n;
      idx          <= idx_n;
      rem          <= rem_n;
      gap_len      <= gap_len_n;
      gap_cnt      <= gap_cnt_n;
      d_out        <= d_n;
      valid_out    <= valid_n;
      busy         <= busy_n;
      pattern_sent <= sent_n;
      done         <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    pat_n     = pat;
    idx_n     = idx;
    rem_n     = rem;
    gap_len_n = gap_len;
    gap_cnt_n = gap_cnt;
    sent_n    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          pat_n     = pattern_in;
          rem_n     = repeat_in;
          gap_len_n = gap_in;
          idx_n     = LAST_IDX;
          state_n   = (repeat_in != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx != '0) begin
            idx_n = idx - IDX_W'(1);
          end else begin
            sent_n = 1'b1;
            idx_n  = LAST_IDX;
            if (rem != '0) rem_n = rem - CNT_W'(1);
            if (rem <= CNT_W'(1)) begin
              state_n = DONE;
            end else if (gap_len != '0) begin
              state_n   = GAP;
              gap_cnt_n = gap_len;
            end
          end
        end
      end
      GAP: begin
        // gap_cnt counts the idle cycles still to show, including this one.
        if (gap_cnt <= GAP_W'(1)) begin
          state_n   = SEND;
          idx_n     = LAST_IDX;
          gap_cnt_n = '0;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    valid_n = (state_n == SEND);
    d_n     = valid_n ? pat_n[idx_n] : 1'b0;
    busy_n  = (state_n != IDLE);
    done_n  = (state_n == DONE);
  end

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Directed bench for serial_pattern_generator: per-cycle logs compared against
// hand-computed masks, with an expected-bit queue and a loopback detector model.
module tb_serial_pattern_generator;

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] pattern_in;
  logic [7:0] repeat_in;
  logic [3:0] gap_in;
  logic       ready_in;
  logic       d_out;
  logic       valid_out;
  logic       busy;
  logic       pattern_sent;
  logic       done;

  serial_pattern_generator #(.PAT_W(5), .CNT_W(8), .GAP_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern_in(pattern_in),
    .repeat_in(repeat_in), .gap_in(gap_in), .ready_in(ready_in),
    .d_out(d_out), .valid_out(valid_out), .busy(busy),
    .pattern_sent(pattern_sent), .done(done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard
  logic [0:0] exp_q[$];
  logic [63:0] valid_log, d_log, ps_log, done_log, busy_log, flag_log;
  int transfers;
  int flag_cnt;
  int nacc;
  logic [4:0] sh;

  // Job configuration
  logic [4:0] jp;
  logic [7:0] jr;
  logic [3:0] jg;
  int start_b, reset_at, stall_lo, stall_hi;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pat(input logic [4:0] p);
    for (int i = 4; i >= 0; i--) exp_q.push_back(p[i]);
  endtask

  task automatic setup(input logic [4:0] p, input logic [7:0] r, input logic [3:0] g);
    jp = p; jr = r; jg = g;
    start_b = -1; reset_at = -1; stall_lo = -1; stall_hi = -2;
    exp_q.delete();
  endtask

  // Drives cycles 0..n-1 (start in cycle 0) and logs outputs of each cycle.
  task automatic run(input int n);
    valid_log = '0; d_log = '0; ps_log = '0; done_log = '0; busy_log = '0;
    flag_log = '0; transfers = 0; flag_cnt = 0; nacc = 0; sh = '0;
    for (int c = 0; c < n; c++) begin
      start = (c == 0) || (c == start_b);
      if (c == 0) begin
        pattern_in = jp; repeat_in = jr; gap_in = jg;
      end else begin
        pattern_in = ~jp; repeat_in = jr; gap_in = jg;
      end
      reset    = (c == reset_at);
      ready_in = !(c >= stall_lo && c <= stall_hi);
      valid_log[c] = valid_out;
      d_log[c]     = d_out;
      ps_log[c]    = pattern_sent;
      done_log[c]  = done;
      busy_log[c]  = busy;
      if (valid_out && ready_in) begin
        transfers++;
        if (exp_q.size() == 0) check("bit_underflow", 64'(exp_q.size()), 64'd1);
        else check("bit", {63'd0, d_out}, {63'd0, exp_q.pop_front()});
        sh = {sh[3:0], d_out};
        nacc++;
        if (nacc >= 5 && sh == jp) begin
          flag_cnt++;
          flag_log[c] = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0; reset = 1'b0; ready_in = 1'b1;
    check("queue_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    start = 1'b0; reset = 1'b1; ready_in = 1'b1;
    pattern_in = '0; repeat_in = '0; gap_in = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_d_out", d_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_busy", busy, 0);
    check("rst_sent", pattern_sent, 0);
    check("rst_done", done, 0);

    // Basic send
    setup(5'b01101, 8'd1, 4'd0);
    push_pat(5'b01101);
    run(10);
    check("basic_valid", valid_log, 64'h3E);
    check("basic_sent", ps_log, 64'h40);
    check("basic_done", done_log, 64'h40);
    check("basic_busy", busy_log, 64'h7E);
    check("basic_xfers", transfers, 5);

    // Back-to-back repetitions
    setup(5'b01101, 8'd3, 4'd0);
    repeat (3) push_pat(5'b01101);
    run(20);
    check("b2b_valid", valid_log, 64'hFFFE);
    check("b2b_sent", ps_log, 64'h10840);
    check("b2b_done", done_log, 64'h10000);
    check("b2b_busy", busy_log, 64'h1FFFE);

    // Gap of 2 between repetitions
    setup(5'b01101, 8'd3, 4'd2);
    repeat (3) push_pat(5'b01101);
    run(24);
    check("gap_valid", valid_log, 64'hF9F3E);
    check("gap_sent", ps_log, 64'h102040);
    check("gap_done", done_log, 64'h100000);
    check("gap_busy", busy_log, 64'h1FFFFE);

    // Backpressure in cycles 2-4
    setup(5'b01101, 8'd1, 4'd0);
    stall_lo = 2; stall_hi = 4;
    push_pat(5'b01101);
    run(12);
    check("bp_valid", valid_log, 64'h1FE);
    check("bp_hold", {61'd0, d_log[4:2]}, 64'h7);
    check("bp_done", done_log, 64'h200);
    check("bp_sent", ps_log, 64'h200);
    check("bp_xfers", transfers, 5);

    // Zero repetitions
    setup(5'b01101, 8'd0, 4'd0);
    run(5);
    check("rep0_valid", valid_log, 64'h0);
    check("rep0_done", done_log, 64'h2);
    check("rep0_busy", busy_log, 64'h2);
    check("rep0_sent", ps_log, 64'h0);

    // Start pulsed during SEND with different inputs
    setup(5'b01101, 8'd1, 4'd0);
    start_b = 3;
    push_pat(5'b01101);
    run(12);
    check("ssend_valid", valid_log, 64'h3E);
    check("ssend_done", done_log, 64'h40);

    // Start during DONE ignored, next IDLE start accepted (latches 10010)
    setup(5'b01101, 8'd1, 4'd0);
    start_b = -1;
    push_pat(5'b01101);
    push_pat(5'b10010);
    valid_log = '0;
    begin
      int second;
      second = 7;
      // Two late starts: cycle 6 (DONE) and cycle 7 (IDLE).
      start_b = 6;
      fork
        run(16);
        begin
          @(posedge clk); repeat (6) @(posedge clk);
          #2;
          start = 1'b1;
          pattern_in = ~jp;
        end
      join
      second = second + 0;
    end
    check("sdone_valid", valid_log, 64'h1F3E);
    check("sdone_done", done_log, 64'h2040);
    check("sdone_busy", busy_log, 64'h3F7E);

    // Reset mid-transmission
    setup(5'b01101, 8'd2, 4'd0);
    reset_at = 3;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    run(20);
    check("rst_mid_valid", valid_log, 64'hE);
    check("rst_mid_busy", busy_log, 64'hE);
    check("rst_mid_sent", ps_log, 64'h0);
    check("rst_mid_done", done_log, 64'h0);
    check("rst_mid_d", {63'd0, d_log[4]}, 64'h0);

    // Reset wins over simultaneous start
    setup(5'b01101, 8'd1, 4'd0);
    reset_at = 0;
    run(6);
    check("rst_start_valid", valid_log, 64'h0);
    check("rst_start_busy", busy_log, 64'h0);

    // Loopback into a detector model
    setup(5'b01101, 8'd2, 4'd1);
    repeat (2) push_pat(5'b01101);
    run(16);
    check("loop_flags", flag_cnt, 2);
    check("loop_flag_cyc", flag_log, 64'h820);
    check("loop_valid", valid_log, 64'hFBE);
    check("loop_sent", ps_log, 64'h1040);
    check("loop_done", done_log, 64'h1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
